// File: rtl/alu_pkg.sv
// Definitions shared by the ALU result path: the multiplexer select codes and
// the layout of one buffered result entry.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  // Select encoding {S1,S0}. The multiplexer and the select generator use the same values.
  localparam logic [1:0] SEL_A0 = 2'b00;
  localparam logic [1:0] SEL_A1 = 2'b01;
  localparam logic [1:0] SEL_A2 = 2'b10;
  localparam logic [1:0] SEL_A3 = 2'b11;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] y;
    logic [1:0]           sel;
    logic                 zero;
    logic                 neg;
  } alu_entry_t;

  // Bits per stored entry: data, a 2-bit select code, and the zero and neg flags.
  function automatic int entry_width(input int data_w);
    return data_w + 4;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic first-word fall-through storage array. It tracks the pointers,
// occupancy and full/empty status. A synchronous clear resets the pointers
// and the occupancy but leaves the stored words untouched.
module alu_result_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // The enables are gated again here, so the array stays consistent even if a caller misuses it.
  assign do_wr = wr_en && !full && !clr;
  assign do_rd = rd_en && !empty && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow performs the wrap.
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_d = count_q + CW'(1);
      else if (do_rd && !do_wr) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU multiplexer results together with their select code and their
// zero/negative flags, and hands them downstream over valid/ready. It also
// counts the results that arrive while the buffer is full.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_y,
  input  logic                   in_s1,
  input  logic                   in_s0,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [1:0]             out_sel,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int EW = entry_width(WIDTH);

  logic              push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     wr_entry, rd_entry;
  logic [DROP_W-1:0] drop_q, drop_d;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;
  assign drop = in_valid && !in_ready && !flush;

  // The flags are captured with the data, so the output path is only a field split.
  assign wr_entry = {in_y, in_s1, in_s0, (in_y == '0), in_y[WIDTH-1]};

  alu_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The stored words survive a flush, so the fields are masked whenever the buffer is empty.
  always_comb begin
    out_y    = '0;
    out_sel  = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (out_valid) begin
      out_y    = rd_entry[EW-1:4];
      out_sel  = rd_entry[3:2];
      out_zero = rd_entry[1];
      out_neg  = rd_entry[0];
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (flush)                       drop_d = '0;
    else if (drop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomised scoreboard bench for alu_result_buffer: an occupancy/queue reference model checked by a negedge monitor.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int DMAX  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_y = 8'h00;
  logic       in_s1 = 1'b0;
  logic       in_s0 = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
  logic [1:0] out_sel;
  logic       out_zero;
  logic       out_neg;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  alu_result_buffer #(.WIDTH(8), .DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_s1(in_s1), .in_s0(in_s0),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sel(out_sel),
    .out_zero(out_zero), .out_neg(out_neg), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // The model holds the current occupancy, the drop total, and the decisions made for the upcoming edge.
  alu_entry_t sb_q[$];
  int  model_cnt = 0;
  int  snap_cnt  = 0;
  int  exp_drop  = 0;
  bit  d_push = 0, d_pop = 0, d_drop = 0, d_flush = 0;
  bit  mon_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply the previous cycle's effect to the model, then drive and decide this cycle.
  task automatic step(input bit v, input logic [7:0] y, input logic [1:0] s, input bit ordy, input bit fl);
    alu_entry_t e;
    @(posedge clk);
    #1;
    if (d_flush) begin
      model_cnt = 0;
      exp_drop  = 0;
      sb_q.delete();
    end else begin
      model_cnt = model_cnt + int'(d_push) - int'(d_pop);
      if (d_drop && exp_drop < DMAX) exp_drop++;
    end
    in_valid  = v;
    in_y      = y;
    in_s1     = s[1];
    in_s0     = s[0];
    out_ready = ordy;
    flush     = fl;
    snap_cnt  = model_cnt;
    d_flush   = fl;
    d_push    = v && (model_cnt < DEPTH) && !fl;
    d_pop     = (model_cnt > 0) && ordy && !fl;
    d_drop    = v && (model_cnt == DEPTH) && !fl;
    if (d_push) begin
      e.y = y; e.sel = s; e.zero = (y == 8'h00); e.neg = (y >= 8'h80);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", int'(count), snap_cnt);
      chk("out_valid", int'(out_valid), int'(snap_cnt != 0));
      chk("in_ready", int'(in_ready), int'(snap_cnt < DEPTH));
      chk("drop_cnt", int'(drop_cnt), exp_drop);
      if (snap_cnt > 0) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard: expected entry missing at %0t", $time);
        end else begin
          chk("head", int'({out_y, out_sel, out_zero, out_neg}), int'(sb_q[0]));
          if (d_pop) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'b00, ordy, 1'b0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_out_y", int'(out_y), 0);
    mon_en = 1;

    // Single capture of a zero result
    step(1'b1, 8'h00, SEL_A2, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Fill, overflow, full with pop, then drain
    step(1'b1, 8'h81, SEL_A1, 1'b0, 1'b0);
    step(1'b1, 8'h02, SEL_A0, 1'b0, 1'b0);
    step(1'b1, 8'h7F, SEL_A3, 1'b0, 1'b0);
    step(1'b1, 8'hFF, SEL_A2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, SEL_A3, 1'b0, 1'b0);
    step(1'b1, 8'hCC, SEL_A1, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Streaming across two pointer wraps
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 2'(i), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Flush with in_valid asserted
    step(1'b1, 8'h11, SEL_A1, 1'b0, 1'b0);
    step(1'b1, 8'h22, SEL_A2, 1'b0, 1'b0);
    step(1'b1, 8'h33, SEL_A3, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Drop counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 2'(i), 1'b0, 1'b0);
    for (int i = 0; i < 262; i++) step(1'b1, 8'h99, SEL_A0, 1'b0, 1'b0);
    idle(6, 1'b1);
    step(1'b0, 8'h00, SEL_A0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    idle(6, 1'b1);

    // Async reset between clock edges with a result held
    step(1'b1, 8'h55, SEL_A1, 1'b0, 1'b0);
    idle(1, 1'b0);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_y", int'(out_y), 0);
    chk("arst_out_sel", int'(out_sel), 0);
    chk("arst_flags", int'({out_zero, out_neg}), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_cnt = 0; snap_cnt = 0; exp_drop = 0;
    d_push = 0; d_pop = 0; d_drop = 0; d_flush = 0;
    sb_q.delete();
    mon_en = 1;
    step(1'b1, 8'h80, SEL_A3, 1'b0, 1'b0);
    idle(2, 1'b1);
    mon_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit 4:1 ALU result multiplexer.
- Captures each selected result Y together with its select code (S1,S0) and derives zero/negative flags.
- Buffers up to DEPTH results in a FIFO and hands them to the display/register-file stage over a valid/ready handshake.
- Counts results the multiplexer presented while the buffer was full, so sequencing errors are visible on the board.

Parameters:
- WIDTH, 8: data width of Y; must match the multiplexer.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO contents and drop counter.
- in_valid  input  1  in_y/in_s1/in_s0 hold a result to capture.
- in_ready  output  1  buffer can accept; equals !full.
- in_y  input  WIDTH  multiplexer output Y.
- in_s1  input  1  multiplexer select S1.
- in_s0  input  1  multiplexer select S0.
- out_valid  output  1  head entry is present; equals count!=0.
- out_ready  input  1  consumer accepts the head entry.
- out_y  output  WIDTH  head result.
- out_sel  output  2  head select code {S1,S0}.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_cnt  output  DROP_W  saturating count of refused inputs.

Behaviour:
- Reset: rst_n low asynchronously clears write pointer, read pointer, count and drop_cnt to 0, and clears all storage to 0. Consequences while in reset: out_valid=0, out_y=0, out_sel=0, out_zero=0, out_neg=0, in_ready=1. Reset asserted mid-transfer discards all entries; no partial state survives.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- Push: at the edge, store {in_y, in_s1, in_s0, zero=(in_y==0), neg=in_y[WIDTH-1]} at the write pointer, then increment the write pointer mod DEPTH.
  - Flags are computed at capture and stored, not recomputed at the output.
- Pop: increment the read pointer mod DEPTH. Storage is not cleared on pop.
- Output path: out_* come combinationally from the storage entry at the read pointer, so the FIFO is first-word fall-through.
  - A push into an empty FIFO at edge t gives out_valid=1 with that data during the cycle after t. Latency is 1 cycle.
- Count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Full (count==DEPTH): in_ready=0, even if the same cycle pops. Push is not allowed while full, regardless of pop.
- Empty (count==0): out_valid=0; out_ready is ignored. A push and a pop cannot coincide while empty.
- Pointer wrap: from DEPTH-1 to 0 with no bubble. Order is strictly FIFO across the wrap.
- Drop counter: increments when in_valid && !in_ready && !flush, and saturates at 2^DROP_W-1 (no wrap).
- Flush: takes priority over push, pop and drop.
  - At the edge it sets pointers, count and drop_cnt to 0.
  - Storage contents are left as-is, but out_valid=0 afterwards.
  - Inputs presented during the flush cycle are neither captured nor counted as drops.
- Simultaneous push and pop while partially full: both take effect and count is unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - SEL_A0=2'b00, SEL_A1=2'b01, SEL_A2=2'b10, SEL_A3=2'b11 (encoding {S1,S0}), shared with the multiplexer and the select generator.
  - Default ALU_WIDTH=8.
  - A packed entry type {y, sel, zero, neg}.
- One natural sub-module: alu_result_fifo, a generic storage array with pointers, count and full/empty.
  - Flag generation, handshake gating, flush and the drop counter stay in alu_result_buffer.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> out_valid=0, in_ready=1, count=0, drop_cnt=0, out_y=0.
- Single capture: push in_y=8'h00, sel=2'b10 with out_ready=0 -> next cycle out_valid=1, out_y=00, out_sel=2, out_zero=1, out_neg=0, count=1.
- Fill and overflow: push 8'h81,8'h02,8'h7F,8'hFF with out_ready=0, then hold in_valid 3 more cycles -> count=4, in_ready=0, drop_cnt=3. Then drain -> 81(neg=1), 02, 7F, FF(neg=1) in order.
- Streaming with wrap: in_valid=1 and out_ready=1 continuously for 10 values 1..10 -> outputs 1..10 in order, count never above 1, drop_cnt=0, pointers wrap twice.
- Full plus pop in the same cycle: with count=4, assert out_ready and in_valid together -> one pop, no push, count=3, drop_cnt+1.
- Flush and async reset mid-operation: with count=2, assert flush together with in_valid -> next cycle count=0, out_valid=0, drop_cnt=0. Then push 8'h55 and pulse rst_n low between clock edges -> outputs clear immediately, without waiting for a clock edge.
